// File: rtl/efpga_cfg_pkg.sv
// Shared definitions for the eFPGA configuration frame loader:
// session control words, FSM state encoding and header field positions.
package efpga_cfg_pkg;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  // Header layout: block word count in the upper half, frame address in the low bits.
  localparam int HDR_COUNT_MSB = 31;
  localparam int HDR_COUNT_LSB = 16;
  localparam int HDR_ADDR_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } load_state_e;

  // Extract the block word count from a header word.
  function automatic logic [15:0] hdr_count(input logic [31:0] word);
    return word[HDR_COUNT_MSB:HDR_COUNT_LSB];
  endfunction

endpackage

// File: rtl/frame_select_decoder.sv
// Binary-to-one-hot frame select decoder with enable.
// Ports:
//   addr_i    binary frame address
//   en_i      enable; when low the output is all zeros
//   select_o  one-hot decode of addr_i (zero for out-of-range addresses)
module frame_select_decoder #(
  parameter int NUM_FRAMES   = 32,
  parameter int FRAME_ADDR_W = 5
) (
  input  logic [FRAME_ADDR_W-1:0] addr_i,
  input  logic                    en_i,
  output logic [NUM_FRAMES-1:0]   select_o
);

  // One-hot decode, suppressed when disabled or when the address is out of range.
  always_comb begin
    select_o = '0;
    if (en_i && ({1'b0, addr_i} < (FRAME_ADDR_W+1)'(NUM_FRAMES))) begin
      select_o = {{(NUM_FRAMES-1){1'b0}}, 1'b1} << addr_i;
    end else begin
      select_o = '0;
    end
  end

endmodule

// File: rtl/efpga_frame_loader.sv
// Parses the 32-bit configuration word stream into framed writes to the eFPGA fabric.
// Ports:
//   clk_i, reset_n_i  clock and asynchronous active-low reset
//   word_i            configuration word, valid with word_strobe_i
//   word_strobe_i     one-cycle word-valid pulse
//   frame_data_o      frame data to the fabric (held between writes)
//   frame_addr_o      binary frame address of the current write (held between writes)
//   frame_select_o    one-hot frame select, only during the write pulse
//   frame_strobe_o    one-cycle write pulse
//   active_o          session in progress (HEADER or DATA)
//   done_o            sticky: DESYNC seen; cleared by next SYNC
//   error_o           sticky: address overflow; cleared by next SYNC
module efpga_frame_loader
  import efpga_cfg_pkg::*;
#(
  parameter int          NUM_FRAMES   = 32,
  parameter int          FRAME_ADDR_W = 5,
  parameter logic [31:0] SYNC_WORD    = efpga_cfg_pkg::SYNC_WORD,
  parameter logic [31:0] DESYNC_WORD  = efpga_cfg_pkg::DESYNC_WORD
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [31:0]             word_i,
  input  logic                    word_strobe_i,
  output logic [31:0]             frame_data_o,
  output logic [FRAME_ADDR_W-1:0] frame_addr_o,
  output logic [NUM_FRAMES-1:0]   frame_select_o,
  output logic                    frame_strobe_o,
  output logic                    active_o,
  output logic                    done_o,
  output logic                    error_o
);

  localparam logic [FRAME_ADDR_W:0] NUM_FRAMES_X = (FRAME_ADDR_W+1)'(NUM_FRAMES);

  load_state_e             state_r, state_s;
  logic [15:0]             count_r, count_s;
  logic [FRAME_ADDR_W-1:0] addr_r, addr_s;
  logic                    done_r, done_s;
  logic                    error_r, error_s;
  logic                    wr_s;
  logic [31:0]             frame_data_r;
  logic [FRAME_ADDR_W-1:0] frame_addr_r;
  logic                    frame_strobe_r;
  logic                    active_r;
  logic [NUM_FRAMES-1:0]   frame_select_r, select_s;
  logic [15:0]             hdr_count_s;
  logic [FRAME_ADDR_W-1:0] hdr_addr_s;

  assign hdr_count_s = hdr_count(word_i);
  assign hdr_addr_s  = word_i[HDR_ADDR_LSB +: FRAME_ADDR_W];

  // Next-state, counter and write decisions for each accepted word.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    addr_s  = addr_r;
    done_s  = done_r;
    error_s = error_r;
    wr_s    = 1'b0;
    if (word_strobe_i) begin
      case (state_r)
        ST_IDLE: begin
          if (word_i == SYNC_WORD) begin
            state_s = ST_HEADER;
            done_s  = 1'b0;
            error_s = 1'b0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HEADER: begin
          if (word_i == DESYNC_WORD) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else if (word_i == SYNC_WORD) begin
            // Re-sync inside a session is harmless and ignored.
            state_s = ST_HEADER;
          end else if (hdr_count_s == 16'd0) begin
            state_s = ST_HEADER;
          end else if ({1'b0, hdr_addr_s} >= NUM_FRAMES_X) begin
            state_s = ST_IDLE;
            error_s = 1'b1;
          end else begin
            state_s = ST_DATA;
            count_s = hdr_count_s;
            addr_s  = hdr_addr_s;
          end
        end
        ST_DATA: begin
          // Every word is payload here, even ones matching SYNC/DESYNC.
          wr_s    = 1'b1;
          count_s = count_r - 16'd1;
          addr_s  = addr_r + FRAME_ADDR_W'(1);
          if (count_r == 16'd1) begin
            state_s = ST_HEADER;
          end else if (({1'b0, addr_r} + (FRAME_ADDR_W+1)'(1)) >= NUM_FRAMES_X) begin
            // Block would run past the last frame: abort after this write.
            state_s = ST_IDLE;
            error_s = 1'b1;
          end else begin
            state_s = ST_DATA;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  frame_select_decoder #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_ADDR_W(FRAME_ADDR_W)
  ) u_select_dec (
    .addr_i  (addr_r),
    .en_i    (wr_s),
    .select_o(select_s)
  );

  // State, counters, status flags and registered fabric outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r        <= ST_IDLE;
      count_r        <= 16'd0;
      addr_r         <= '0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      active_r       <= 1'b0;
      frame_data_r   <= 32'd0;
      frame_addr_r   <= '0;
      frame_strobe_r <= 1'b0;
      frame_select_r <= '0;
    end else begin
      state_r        <= state_s;
      count_r        <= count_s;
      addr_r         <= addr_s;
      done_r         <= done_s;
      error_r        <= error_s;
      active_r       <= (state_s != ST_IDLE);
      frame_strobe_r <= wr_s;
      frame_select_r <= select_s;
      if (wr_s) begin
        frame_data_r <= word_i;
        frame_addr_r <= addr_r;
      end
    end
  end

  assign frame_data_o   = frame_data_r;
  assign frame_addr_o   = frame_addr_r;
  assign frame_select_o = frame_select_r;
  assign frame_strobe_o = frame_strobe_r;
  assign active_o       = active_r;
  assign done_o         = done_r;
  assign error_o        = error_r;

endmodule

// File: tb/tb_efpga_frame_loader.sv
// Self-checking bench for efpga_frame_loader: directed scenarios followed by
// randomized word streams, all compared against a behavioural session model.
module tb_efpga_frame_loader;

  localparam int          NF     = 32;
  localparam int          AW     = 5;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [31:0]   word_i = 32'd0;
  logic          word_strobe_i = 1'b0;
  logic [31:0]   frame_data_o;
  logic [AW-1:0] frame_addr_o;
  logic [NF-1:0] frame_select_o;
  logic          frame_strobe_o;
  logic          active_o;
  logic          done_o;
  logic          error_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: session flag, inside-block flag, words left, next address.
  bit          m_sess, m_block;
  int          m_left, m_next;
  bit          e_stb, e_done, e_err;
  logic [31:0] e_data;
  int          e_addr;

  efpga_frame_loader dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .word_i        (word_i),
    .word_strobe_i (word_strobe_i),
    .frame_data_o  (frame_data_o),
    .frame_addr_o  (frame_addr_o),
    .frame_select_o(frame_select_o),
    .frame_strobe_o(frame_strobe_o),
    .active_o      (active_o),
    .done_o        (done_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sess = 0; m_block = 0; m_left = 0; m_next = 0;
    e_stb = 0; e_done = 0; e_err = 0; e_data = 32'd0; e_addr = 0;
  endtask

  // Apply one cycle's input to the model, producing the expected outputs one cycle later.
  task automatic model_step(input bit stb, input logic [31:0] w);
    int cnt, a;
    e_stb = 0;
    if (!stb) return;
    if (!m_sess) begin
      if (w == SYNC) begin m_sess = 1; m_block = 0; e_done = 0; e_err = 0; end
    end else if (!m_block) begin
      cnt = int'(w >> 16);
      a   = int'(w % NF);
      if (w == DESYNC) begin m_sess = 0; e_done = 1; end
      else if (w == SYNC) begin end
      else if (cnt == 0) begin end
      else begin m_block = 1; m_left = cnt; m_next = a; end
    end else begin
      e_stb = 1; e_data = w; e_addr = m_next;
      m_left = m_left - 1;
      m_next = m_next + 1;
      if (m_left == 0) m_block = 0;
      else if (m_next >= NF) begin m_sess = 0; m_block = 0; e_err = 1; end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NF-1:0] esel;
    esel = e_stb ? (NF'(1) << e_addr) : '0;
    check_val({tag, ".strobe"}, 64'(frame_strobe_o), 64'(e_stb));
    check_val({tag, ".select"}, 64'(frame_select_o), 64'(esel));
    check_val({tag, ".data"},   64'(frame_data_o),   64'(e_data));
    check_val({tag, ".addr"},   64'(frame_addr_o),   64'(e_addr));
    check_val({tag, ".done"},   64'(done_o),         64'(e_done));
    check_val({tag, ".error"},  64'(error_o),        64'(e_err));
    check_val({tag, ".active"}, 64'(active_o),       64'(m_sess));
  endtask

  // One clock: drive inputs at the negedge, check the result at the next negedge.
  task automatic step(input string tag, input bit stb, input logic [31:0] w);
    word_i = w; word_strobe_i = stb;
    model_step(stb, w);
    @(negedge clk_i);
    word_strobe_i = 1'b0;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n_i = 1'b0;
    word_strobe_i = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  function automatic logic [31:0] hdr(input int cnt, input int a);
    return {16'(cnt), 16'(a)};
  endfunction

  initial begin
    model_reset();
    @(negedge clk_i);
    check_outputs("reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // 1: basic block of three back-to-back words
    step("t1", 1, SYNC);
    step("t1", 1, hdr(3, 2));
    step("t1", 1, 32'hD000_0000);
    step("t1", 1, 32'hD000_0001);
    step("t1", 1, 32'hD000_0002);
    step("t1", 1, DESYNC);
    step("t1", 0, 32'h0);

    // 2: words before SYNC are dropped
    step("t2", 1, 32'h1234_5678);
    step("t2", 1, DESYNC);
    step("t2", 0, 32'h0);

    // 3: address overflow
    step("t3", 1, SYNC);
    step("t3", 1, hdr(4, 30));
    step("t3", 1, 32'hAAAA_0001);
    step("t3", 1, 32'hAAAA_0002);
    step("t3", 1, 32'hAAAA_0003);

    // 4: control words are data inside a block
    step("t4", 1, SYNC);
    step("t4", 1, hdr(1, 0));
    step("t4", 1, DESYNC);
    step("t4", 1, DESYNC);

    // 5: empty block then a single-word block
    step("t5", 1, SYNC);
    step("t5", 1, hdr(0, 5));
    step("t5", 1, SYNC);
    step("t5", 1, hdr(1, 5));
    step("t5", 1, 32'h5555_AAAA);
    step("t5", 0, 32'h0);

    // 6: reset mid-block, then data ignored until SYNC
    step("t6", 1, SYNC);
    step("t6", 1, hdr(3, 10));
    step("t6", 1, 32'h6666_0000);
    do_reset("t6");
    step("t6", 1, 32'h6666_0001);
    step("t6", 1, 32'h6666_0002);
    step("t6", 1, SYNC);
    step("t6", 1, hdr(1, 7));
    step("t6", 1, 32'h6666_0003);

    // Randomized streams
    for (int i = 0; i < 2000; i++) begin
      int sel;
      logic [31:0] w;
      sel = $urandom_range(0, 99);
      if (sel < 8)       w = SYNC;
      else if (sel < 14) w = DESYNC;
      else if (sel < 45) w = hdr($urandom_range(0, 6), $urandom_range(0, NF - 1));
      else               w = $urandom;
      step("rand", ($urandom_range(0, 9) < 8), w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
